// File: rtl/clock_period_monitor_if.sv
// Signal bundle between a divided-clock source and its period monitor.
// The source side (master) drives the slow clock. The monitor side (slave)
// returns the period measurement, the lock state and the fault pulses.
interface clock_period_monitor_if #(
  parameter int WIDTH = 8
);
  logic             clk_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             period_error;
  logic             clock_lost;

  modport master (
    output clk_in,
    input  period,
    input  high_time,
    input  period_valid,
    input  locked,
    input  period_error,
    input  clock_lost
  );

  modport slave (
    input  clk_in,
    output period,
    output high_time,
    output period_valid,
    output locked,
    output period_error,
    output clock_lost
  );
endinterface

// File: rtl/clock_period_monitor.sv
// clock_period_monitor: measures the period of a slow, asynchronous clock
// (clk_in) in clock8 cycles. It reports every measured period, asserts
// locked after LOCK_COUNT consecutive in-tolerance periods, and pulses
// period_error or clock_lost when the clock misbehaves.
// Optional feature macro: CLOCK_MONITOR_DUTY_EN. When defined, the monitor
// also measures the high time of each period and folds the duty cycle into
// the good/bad decision. When undefined, high_time is tied to 0.
module clock_period_monitor #(
  parameter int WIDTH      = 8,
  parameter int EXPECTED   = 100,
  parameter int TOLERANCE  = 2,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 200
) (
  input  logic                   clock8,
  input  logic                   reset,
  clock_period_monitor_if.slave  mon_if
);

  // Width of the good-period counter: must hold values 0..LOCK_COUNT.
  localparam int GCW = $clog2(LOCK_COUNT + 1);

  // Comparisons against EXPECTED are done one bit wider than the counter so
  // that the absolute difference never wraps.
  localparam logic [WIDTH:0]   EXP_EXT     = (WIDTH + 1)'(EXPECTED);
  localparam logic [WIDTH:0]   TOL_EXT     = (WIDTH + 1)'(TOLERANCE);
  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);
  localparam logic [GCW-1:0]   GC_LAST     = GCW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Synchronizer and edge history
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_edge;

  // FSM state and measurement registers
  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [GCW-1:0]   r_gcnt;
  logic [GCW-1:0]   w_gcnt_next;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] w_period_next;

  // Registered status and pulse outputs
  logic r_valid;
  logic w_valid_next;
  logic r_err;
  logic w_err_next;
  logic r_lost;
  logic w_lost_next;
  logic r_locked;
  logic w_locked_next;

  // Period tolerance check
  logic [WIDTH:0] w_cnt_ext;
  logic [WIDTH:0] w_diff;
  logic           w_period_ok;
  logic           w_good;
  logic           w_timeout;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clock8) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= mon_if.clk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Saturating increment keeps the counter pinned at its maximum instead
  // of wrapping back into the tolerance window.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  assign w_cnt_ext   = {1'b0, r_cnt};
  assign w_diff      = (w_cnt_ext >= EXP_EXT) ? (w_cnt_ext - EXP_EXT)
                                              : (EXP_EXT - w_cnt_ext);
  assign w_period_ok = (w_diff <= TOL_EXT);
  assign w_timeout   = (r_cnt == TIMEOUT_CNT);

`ifdef CLOCK_MONITOR_DUTY_EN
  localparam logic [WIDTH:0] HALF_EXT = (WIDTH + 1)'(EXPECTED / 2);

  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_high_time;
  logic [WIDTH:0]   w_hcnt_ext;
  logic [WIDTH:0]   w_hdiff;
  logic             w_high_ok;

  // High-time counter: the edge cycle itself has s2 high, so an edge
  // restarts the count at 1 rather than 0.
  always_ff @(posedge clock8) begin
    if (reset) begin
      r_hcnt <= '0;
    end else if (w_edge) begin
      r_hcnt <= CNT_ONE;
    end else if (r_state == ST_SEARCH) begin
      r_hcnt <= '0;
    end else if (r_s2 && (r_hcnt != CNT_MAX)) begin
      r_hcnt <= r_hcnt + CNT_ONE;
    end
  end

  // Capture the high time alongside each reported period.
  always_ff @(posedge clock8) begin
    if (reset) begin
      r_high_time <= '0;
    end else if (w_valid_next) begin
      r_high_time <= r_hcnt;
    end
  end

  assign w_hcnt_ext = {1'b0, r_hcnt};
  assign w_hdiff    = (w_hcnt_ext >= HALF_EXT) ? (w_hcnt_ext - HALF_EXT)
                                               : (HALF_EXT - w_hcnt_ext);
  assign w_high_ok  = (w_hdiff <= TOL_EXT);
  assign w_good     = w_period_ok & w_high_ok;

  assign mon_if.high_time = r_high_time;
`else
  assign w_good           = w_period_ok;
  assign mon_if.high_time = '0;
`endif

  // Next-state, counter and output decode. An edge always takes priority
  // over the timeout, so a period of exactly TIMEOUT is reported (as bad).
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = w_cnt_inc;
    w_gcnt_next   = r_gcnt;
    w_period_next = r_period;
    w_valid_next  = 1'b0;
    w_err_next    = 1'b0;
    w_lost_next   = 1'b0;
    w_locked_next = r_locked;

    case (r_state)
      ST_SEARCH: begin
        // First edge only starts a measurement; nothing to report yet.
        w_cnt_next = '0;
        if (w_edge) begin
          w_state_next = ST_ACQUIRE;
          w_cnt_next   = CNT_ONE;
          w_gcnt_next  = '0;
        end
      end

      ST_ACQUIRE: begin
        if (w_edge) begin
          w_cnt_next    = CNT_ONE;
          w_period_next = r_cnt;
          w_valid_next  = 1'b1;
          if (w_good) begin
            w_gcnt_next = r_gcnt + GCW'(1);
            if (r_gcnt == GC_LAST) begin
              w_state_next  = ST_LOCKED;
              w_locked_next = 1'b1;
            end
          end else begin
            w_gcnt_next = '0;
          end
        end else if (w_timeout) begin
          w_state_next  = ST_SEARCH;
          w_cnt_next    = '0;
          w_gcnt_next   = '0;
          w_lost_next   = 1'b1;
          w_locked_next = 1'b0;
        end
      end

      ST_LOCKED: begin
        if (w_edge) begin
          w_cnt_next    = CNT_ONE;
          w_period_next = r_cnt;
          w_valid_next  = 1'b1;
          if (!w_good) begin
            w_state_next  = ST_ACQUIRE;
            w_gcnt_next   = '0;
            w_err_next    = 1'b1;
            w_locked_next = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_next  = ST_SEARCH;
          w_cnt_next    = '0;
          w_gcnt_next   = '0;
          w_lost_next   = 1'b1;
          w_locked_next = 1'b0;
        end
      end

      default: begin
        w_state_next  = ST_SEARCH;
        w_cnt_next    = '0;
        w_gcnt_next   = '0;
        w_locked_next = 1'b0;
      end
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clock8) begin
    if (reset) begin
      r_state  <= ST_SEARCH;
      r_cnt    <= '0;
      r_gcnt   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_lost   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_gcnt   <= w_gcnt_next;
      r_period <= w_period_next;
      r_valid  <= w_valid_next;
      r_err    <= w_err_next;
      r_lost   <= w_lost_next;
      r_locked <= w_locked_next;
    end
  end

  assign mon_if.period       = r_period;
  assign mon_if.period_valid = r_valid;
  assign mon_if.period_error = r_err;
  assign mon_if.clock_lost   = r_lost;
  assign mon_if.locked       = r_locked;

endmodule
